dcmi_capture_seq: RTL and testbench
===================================

// Module: dcmi_capture_seq
// PURPOSE
//  Frame/line capture sequencer in the pclk domain, placed between the pclk-polarity/sync front end and the dcmi_ctrl pixel packer.
//  Decides which frames and lines are captured (snapshot/continuous, frame_sel_mode, line_sel_mode).
//  Qualifies the pixel stream with line_vld and emits frame-start, frame-end, line and error pulses for the psync/irq chain.
// PARAMETERS
//  LINE_CNT_W   14   width of captured-line counter (DCMI_CAPTURE_SEQ_LINE_CNT_EN only)
// PORTS
//  pclk            in   1   pixel clock, polarity already applied
//  rstn            in   1   reset, asynchronous, active-low
//  capture_en      in   1   capture enable, already synced to pclk
//  snapshot_mode   in   1   1: one frame then stop; 0: continuous
//  frame_sel_mode  in   2   00 all, 01 every 2nd, 10 every 4th, 11 treated as 00
//  line_sel_mode   in   1   0 all lines, 1 every 2nd line
//  line_sel_start  in   1   parity of kept line when line_sel_mode=1 (0: 1st)
//  vsync_blank     in   1   1 = vertical blanking (vsync_polarity applied)
//  hsync_blank     in   1   1 = horizontal blanking (hsync_polarity applied)
//  line_vld        out  1   pixel data of the current cycle (1-cycle delayed) belongs to a kept line
//  capture_active  out  1   state == CAPTURE
//  fs_pulse        out  1   1-cycle: captured frame started
//  fe_pulse        out  1   1-cycle: captured frame ended
//  line_pulse      out  1   1-cycle: kept line ended
//  err_pulse       out  1   1-cycle: frame ended inside an active line
//  capture_done    out  1   1-cycle: snapshot frame complete (dcmi_reg clears capture_en)
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, vs_q/hs_q = 1, frm_cnt = 0, line_par = 0.
//  - Edges: vs_q/hs_q register the inputs; fs_e = vs_q & ~vsync_blank, fe_e = ~vs_q & vsync_blank,
//    le_s = hs_q & ~hsync_blank, le_e = ~hs_q & hsync_blank. All outputs are registered, so each is asserted in the cycle after the edge cycle.
//  - frm_sel = (mode 01) ? frm_cnt[0]==0 : (mode 10) ? frm_cnt==0 : 1. frm_cnt is a 2-bit wrap counter.
//  - FSM:
//    IDLE:    capture_en -> WAIT_FS, frm_cnt<=0. A mid-frame enable waits for the next fs_e; the first frame is always kept.
//    WAIT_FS: ~capture_en -> IDLE. fs_e -> CAPTURE if frm_sel (fs_pulse), else SKIP; frm_cnt++ in both cases. fe_e is ignored.
//    CAPTURE: fe_e -> fe_pulse; err_pulse also if ~hs_q (line open).
//             Then: snapshot_mode -> capture_done, IDLE; else capture_en ? WAIT_FS : IDLE.
//             Deassertion of capture_en mid-frame is deferred to frame end.
//    SKIP:    ~capture_en -> IDLE immediately. fe_e -> WAIT_FS.
//  - Lines (CAPTURE only): line_par <= 0 at fs_e and toggles at each le_e.
//    kept = ~line_sel_mode | (line_par == line_sel_start).
//    line_vld <= CAPTURE & ~hsync_blank & kept & ~fe_e. line_pulse at le_e of a kept line.
//  - Simultaneous fe_e and le_e: line_pulse and fe_pulse fire in the same cycle; no err_pulse (hs_q was 0, but the line closed on that edge).
//  - rstn assertion mid-frame: immediate return to reset values. No partial pulses.
// CONFIGURATION
//  DCMI_CAPTURE_SEQ_LINE_CNT_EN defined:
//    extra output line_cnt [LINE_CNT_W-1:0]: kept lines of the current frame, cleared at fs_e, incremented on line_pulse, saturating at all-ones.
//    Reset value 0. Held after fe_pulse until the next fs_e.
//  DCMI_CAPTURE_SEQ_LINE_CNT_EN undefined: port and counter absent. All other behaviour is identical.
// STRUCTURE
//  dcmi_pkg: state encoding (IDLE/WAIT_FS/CAPTURE/SKIP), FRM_SEL_ALL/HALF/QUARTER and LINE_SEL_* constants, shared with dcmi_reg.
//  Sub-module dcmi_edge_det (2 instances, vsync/hsync): registered sample plus rise/fall strobes, reset value 1.
// TESTING
//  1. Continuous, mode 00, 3 frames x 4 lines x 8 px
//     -> 3 fs_pulse and 3 fe_pulse; 12 line_pulse; line_vld high 32 cycles per frame; no err.
//  2. frame_sel_mode=10, 8 frames -> frames 0 and 4 captured; SKIP otherwise; 2 fs_pulse.
//  3. snapshot_mode=1, capture_en held 1
//     -> one frame, capture_done 1 cycle after fe_e; FSM in IDLE; later frames ignored until capture_en toggles 0->1.
//  4. line_sel_mode=1, line_sel_start=1, 6 lines -> line_vld only on lines 1, 3, 5; 3 line_pulse.
//  5. vsync_blank rises with hsync_blank=0 mid-line -> err_pulse and fe_pulse same cycle; line_vld low next cycle.
//  6. capture_en dropped mid-CAPTURE -> frame completes, then IDLE. Dropped in SKIP -> IDLE next cycle.
//     rstn pulsed mid-line -> all outputs 0.

Source files
------------

// File: rtl/dcmi_pkg.sv
// Shared encodings for the DCMI capture path: sequencer states and frame/line
// selection codes, also used by the register block.
package dcmi_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_FS = 2'd1,
    CAPTURE = 2'd2,
    SKIP    = 2'd3
  } cap_state_e;

  localparam logic [1:0] FRM_SEL_ALL     = 2'b00;
  localparam logic [1:0] FRM_SEL_HALF    = 2'b01;
  localparam logic [1:0] FRM_SEL_QUARTER = 2'b10;

  localparam logic LINE_SEL_ALL  = 1'b0;
  localparam logic LINE_SEL_HALF = 1'b1;

  // Decides whether the frame numbered frm_cnt (mod 4) is captured.
  function automatic logic frm_keep(input logic [1:0] mode, input logic [1:0] frm_cnt);
    case (mode)
      FRM_SEL_HALF:    return ~frm_cnt[0];
      FRM_SEL_QUARTER: return frm_cnt == 2'd0;
      default:         return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dcmi_edge_det.sv
// Registered sample of a blanking flag plus combinational rise/fall strobes.
// The sample resets to 1 (blanking) so no edge is seen straight out of reset.
module dcmi_edge_det (
  input  logic pclk,
  input  logic rstn,
  input  logic sig_in,
  output logic smp_q,
  output logic rise,
  output logic fall
);

  logic smp_d;

  always_comb smp_d = sig_in;

  // NOTE: sequential state is written with <= only, so every flop samples the
  // pre-edge value of every other flop regardless of process ordering.
  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) smp_q <= 1'b1;
    else       smp_q <= smp_d;
  end

  assign rise = ~smp_q & sig_in;
  assign fall = smp_q & ~sig_in;

endmodule

// File: rtl/dcmi_capture_seq.sv
// Frame/line capture sequencer: picks captured frames and kept lines, qualifies
// pixels with line_vld and emits fs/fe/line/err/done pulses. Optional kept-line
// counter output line_cnt is built when DCMI_CAPTURE_SEQ_LINE_CNT_EN is defined.
module dcmi_capture_seq
  import dcmi_pkg::*;
`ifdef DCMI_CAPTURE_SEQ_LINE_CNT_EN
#(
  parameter int LINE_CNT_W = 14
)
`endif
(
  input  logic                  pclk,
  input  logic                  rstn,
  input  logic                  capture_en,
  input  logic                  snapshot_mode,
  input  logic [1:0]            frame_sel_mode,
  input  logic                  line_sel_mode,
  input  logic                  line_sel_start,
  input  logic                  vsync_blank,
  input  logic                  hsync_blank,
  output logic                  line_vld,
  output logic                  capture_active,
  output logic                  fs_pulse,
  output logic                  fe_pulse,
  output logic                  line_pulse,
  output logic                  err_pulse,
`ifdef DCMI_CAPTURE_SEQ_LINE_CNT_EN
  output logic [LINE_CNT_W-1:0] line_cnt,
`endif
  output logic                  capture_done
);

  logic vs_q, hs_q;
  logic fs_e, fe_e, le_e;
  logic hs_fall_unused;

  dcmi_edge_det u_vsync_edge (
    .pclk   (pclk),
    .rstn   (rstn),
    .sig_in (vsync_blank),
    .smp_q  (vs_q),
    .rise   (fe_e),
    .fall   (fs_e)
  );

  dcmi_edge_det u_hsync_edge (
    .pclk   (pclk),
    .rstn   (rstn),
    .sig_in (hsync_blank),
    .smp_q  (hs_q),
    .rise   (le_e),
    .fall   (hs_fall_unused)
  );

  cap_state_e state_q, state_d;
  logic [1:0] frm_cnt_q, frm_cnt_d;
  logic       line_par_q, line_par_d;
  logic       snap_lock_q, snap_lock_d;
  logic       line_vld_q, line_vld_d;
  logic       fs_pulse_q, fs_pulse_d;
  logic       fe_pulse_q, fe_pulse_d;
  logic       line_pulse_q, line_pulse_d;
  logic       err_pulse_q, err_pulse_d;
  logic       capture_done_q, capture_done_d;
  logic       kept;

  assign kept = ~line_sel_mode | (line_par_q == line_sel_start);

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d        = state_q;
    frm_cnt_d      = frm_cnt_q;
    line_par_d     = line_par_q;
    // A finished snapshot stays locked until capture_en is seen low.
    snap_lock_d    = snap_lock_q & capture_en;
    fs_pulse_d     = 1'b0;
    fe_pulse_d     = 1'b0;
    line_pulse_d   = 1'b0;
    err_pulse_d    = 1'b0;
    capture_done_d = 1'b0;
    line_vld_d     = (state_q == CAPTURE) & ~hsync_blank & kept & ~fe_e;

    case (state_q)
      IDLE: begin
        if (capture_en && !snap_lock_q) begin
          state_d   = WAIT_FS;
          frm_cnt_d = 2'd0;
        end
      end
      WAIT_FS: begin
        if (!capture_en) begin
          state_d = IDLE;
        end else if (fs_e) begin
          frm_cnt_d  = frm_cnt_q + 2'd1;
          line_par_d = 1'b0;
          if (frm_keep(frame_sel_mode, frm_cnt_q)) begin
            state_d    = CAPTURE;
            fs_pulse_d = 1'b1;
          end else begin
            state_d = SKIP;
          end
        end
      end
      CAPTURE: begin
        if (le_e) begin
          line_par_d   = ~line_par_q;
          line_pulse_d = kept;
        end
        if (fe_e) begin
          fe_pulse_d  = 1'b1;
          // Line still open after this edge; a line closing on the same edge is clean.
          err_pulse_d = ~hs_q & ~hsync_blank;
          if (snapshot_mode) begin
            capture_done_d = 1'b1;
            snap_lock_d    = capture_en;
            state_d        = IDLE;
          end else begin
            state_d = capture_en ? WAIT_FS : IDLE;
          end
        end
      end
      SKIP: begin
        if (!capture_en)  state_d = IDLE;
        else if (fe_e)    state_d = WAIT_FS;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= IDLE;
      frm_cnt_q      <= 2'd0;
      line_par_q     <= 1'b0;
      snap_lock_q    <= 1'b0;
      line_vld_q     <= 1'b0;
      fs_pulse_q     <= 1'b0;
      fe_pulse_q     <= 1'b0;
      line_pulse_q   <= 1'b0;
      err_pulse_q    <= 1'b0;
      capture_done_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      frm_cnt_q      <= frm_cnt_d;
      line_par_q     <= line_par_d;
      snap_lock_q    <= snap_lock_d;
      line_vld_q     <= line_vld_d;
      fs_pulse_q     <= fs_pulse_d;
      fe_pulse_q     <= fe_pulse_d;
      line_pulse_q   <= line_pulse_d;
      err_pulse_q    <= err_pulse_d;
      capture_done_q <= capture_done_d;
    end
  end

`ifdef DCMI_CAPTURE_SEQ_LINE_CNT_EN
  logic [LINE_CNT_W-1:0] line_cnt_q, line_cnt_d;

  always_comb begin
    line_cnt_d = line_cnt_q;
    if (fs_pulse_d)                       line_cnt_d = '0;
    else if (line_pulse_d && !(&line_cnt_q)) line_cnt_d = line_cnt_q + 1'b1;
  end

  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) line_cnt_q <= '0;
    else       line_cnt_q <= line_cnt_d;
  end

  assign line_cnt = line_cnt_q;
`endif

  assign line_vld       = line_vld_q;
  assign capture_active = (state_q == CAPTURE);
  assign fs_pulse       = fs_pulse_q;
  assign fe_pulse       = fe_pulse_q;
  assign line_pulse     = line_pulse_q;
  assign err_pulse      = err_pulse_q;
  assign capture_done   = capture_done_q;

endmodule

// File: tb/tb_dcmi_capture_seq.sv
// Scoreboard bench for dcmi_capture_seq: expected pulse events (with line_vld
// cycle counts) are queued as frames are driven and matched as pulses appear.
module tb_dcmi_capture_seq;

  logic       pclk = 1'b0;
  logic       rstn = 1'b0;
  logic       capture_en = 1'b0;
  logic       snapshot_mode = 1'b0;
  logic [1:0] frame_sel_mode = 2'b00;
  logic       line_sel_mode = 1'b0;
  logic       line_sel_start = 1'b0;
  logic       vsync_blank = 1'b1;
  logic       hsync_blank = 1'b1;
  logic       line_vld, capture_active, fs_pulse, fe_pulse;
  logic       line_pulse, err_pulse, capture_done;
`ifdef DCMI_CAPTURE_SEQ_LINE_CNT_EN
  logic [13:0] line_cnt;
`endif

  dcmi_capture_seq dut (
    .pclk           (pclk),
    .rstn           (rstn),
    .capture_en     (capture_en),
    .snapshot_mode  (snapshot_mode),
    .frame_sel_mode (frame_sel_mode),
    .line_sel_mode  (line_sel_mode),
    .line_sel_start (line_sel_start),
    .vsync_blank    (vsync_blank),
    .hsync_blank    (hsync_blank),
    .line_vld       (line_vld),
    .capture_active (capture_active),
    .fs_pulse       (fs_pulse),
    .fe_pulse       (fe_pulse),
    .line_pulse     (line_pulse),
    .err_pulse      (err_pulse),
`ifdef DCMI_CAPTURE_SEQ_LINE_CNT_EN
    .line_cnt       (line_cnt),
`endif
    .capture_done   (capture_done)
  );

  always #5 pclk = ~pclk;

  typedef enum int {EV_FS, EV_LINE, EV_FE, EV_ERR, EV_DONE} ev_e;
  typedef struct {
    ev_e kind;
    int  val;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  run_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  task automatic push(input ev_e k, input int v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  // Expected events for a captured frame: fs, kept lines, clean fe.
  task automatic expect_frame(input int n_lines, input int px, input bit sel_half,
                              input bit sel_start, input bit with_fe);
    push(EV_FS, 0);
    for (int i = 0; i < n_lines; i++)
      if (!sel_half || ((i % 2) == int'(sel_start))) push(EV_LINE, px);
    if (with_fe) push(EV_FE, 0);
  endtask

  task automatic observe(input ev_e k);
    ev_t e;
    check({"pending ", k.name()}, exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({"event kind, expected ", e.kind.name()}, k, e.kind);
      check({"line_vld cycles at ", k.name()}, run_cnt, e.val);
    end
  endtask

  always @(negedge pclk) begin
    if (!rstn) begin
      run_cnt = 0;
    end else begin
      if (fs_pulse) observe(EV_FS);
      if (line_pulse) begin
        observe(EV_LINE);
        check("capture_active at line_pulse", capture_active, !fe_pulse);
        run_cnt = 0;
      end
      if (fe_pulse) begin
        observe(EV_FE);
        run_cnt = 0;
      end
      if (err_pulse) begin
        observe(EV_ERR);
        check("err_pulse with fe_pulse", fe_pulse, 1);
      end
      if (capture_done) begin
        observe(EV_DONE);
        check("capture_done with fe_pulse", fe_pulse, 1);
      end
      if (line_vld) run_cnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, " line_vld"},       line_vld, 0);
    check({tag, " capture_active"}, capture_active, 0);
    check({tag, " fs_pulse"},       fs_pulse, 0);
    check({tag, " fe_pulse"},       fe_pulse, 0);
    check({tag, " line_pulse"},     line_pulse, 0);
    check({tag, " err_pulse"},      err_pulse, 0);
    check({tag, " capture_done"},   capture_done, 0);
  endtask

  // tail: 0 clean end, 1 frame ends inside an open 3-px line, 2 last line and
  // frame end on the same edge. en_ctl at line 1: 1 drop capture_en,
  // 2 pulse capture_en low for 2 cycles, 3 pulse rstn mid-line.
  task automatic drive_frame(input int n_lines, input int px, input int tail, input int en_ctl);
    vsync_blank = 1'b1;
    hsync_blank = 1'b1;
    cyc(3);
    vsync_blank = 1'b0;
    cyc(2);
    for (int i = 0; i < n_lines; i++) begin
      if (i == 1 && en_ctl == 1) capture_en = 1'b0;
      hsync_blank = 1'b0;
      if (i == 1 && en_ctl == 2) begin
        cyc(2); capture_en = 1'b0; cyc(2); capture_en = 1'b1; cyc(px - 4);
      end else if (i == 1 && en_ctl == 3) begin
        cyc(4); rstn = 1'b0; #1;
        reset_checks("mid-line reset");
        cyc(2); rstn = 1'b1; cyc(px - 4);
      end else begin
        cyc(px);
      end
      if (tail == 2 && i == n_lines - 1) break;
      hsync_blank = 1'b1;
      cyc(3);
    end
    if (tail == 1) begin
      hsync_blank = 1'b0;
      cyc(3);
    end
    if (tail == 2) hsync_blank = 1'b1;
    vsync_blank = 1'b1;
    cyc(1);
    hsync_blank = 1'b1;
    cyc(4);
  endtask

  task automatic end_test(input string name);
    cyc(5);
    check({name, ": unmatched expected events"}, exp_q.size(), 0);
    exp_q.delete();
    capture_en = 1'b0;
    cyc(3);
  endtask

  initial begin
    #2;
    reset_checks("reset");
    cyc(2);
    rstn = 1'b1;
    cyc(2);
    check("idle capture_active", capture_active, 0);

    // Continuous, all frames, 3 frames x 4 lines x 8 px.
    capture_en = 1'b1;
    for (int f = 0; f < 3; f++) begin
      expect_frame(4, 8, 1'b0, 1'b0, 1'b1);
      drive_frame(4, 8, 0, 0);
    end
`ifdef DCMI_CAPTURE_SEQ_LINE_CNT_EN
    check("line_cnt held after frame", line_cnt, 4);
`endif
    check("capture_active between frames", capture_active, 0);
    end_test("continuous");

    // Every 4th frame: frames 0 and 4 of 8.
    frame_sel_mode = 2'b10;
    capture_en = 1'b1;
    for (int f = 0; f < 8; f++) begin
      if (f == 0 || f == 4) expect_frame(2, 6, 1'b0, 1'b0, 1'b1);
      drive_frame(2, 6, 0, 0);
    end
    end_test("every 4th frame");
    frame_sel_mode = 2'b00;

    // Snapshot: one frame, then locked until capture_en toggles.
    snapshot_mode = 1'b1;
    capture_en = 1'b1;
    expect_frame(2, 5, 1'b0, 1'b0, 1'b1);
    push(EV_DONE, 0);
    for (int f = 0; f < 3; f++) drive_frame(2, 5, 0, 0);
    check("snapshot idle capture_active", capture_active, 0);
    check("snapshot later frames ignored", exp_q.size(), 0);
    capture_en = 1'b0;
    cyc(2);
    capture_en = 1'b1;
    expect_frame(2, 5, 1'b0, 1'b0, 1'b1);
    push(EV_DONE, 0);
    drive_frame(2, 5, 0, 0);
    end_test("snapshot");
    snapshot_mode = 1'b0;

    // Every 2nd line starting with line 1 of 6.
    line_sel_mode  = 1'b1;
    line_sel_start = 1'b1;
    capture_en = 1'b1;
    expect_frame(6, 8, 1'b1, 1'b1, 1'b1);
    drive_frame(6, 8, 0, 0);
    end_test("line select");
    line_sel_mode  = 1'b0;
    line_sel_start = 1'b0;

    // Frame ends inside an open line, then line and frame ending together.
    capture_en = 1'b1;
    expect_frame(2, 8, 1'b0, 1'b0, 1'b0);
    push(EV_FE, 3);
    push(EV_ERR, 0);
    drive_frame(2, 8, 1, 0);
    expect_frame(3, 8, 1'b0, 1'b0, 1'b1);
    drive_frame(3, 8, 2, 0);
    end_test("frame end boundaries");

    // capture_en dropped inside a captured frame: frame completes, then idle.
    capture_en = 1'b1;
    expect_frame(3, 6, 1'b0, 1'b0, 1'b1);
    drive_frame(3, 6, 0, 1);
    drive_frame(3, 6, 0, 0);
    end_test("drop in capture");

    // capture_en pulsed low in a skipped frame restarts frame selection.
    frame_sel_mode = 2'b10;
    capture_en = 1'b1;
    expect_frame(2, 6, 1'b0, 1'b0, 1'b1);
    drive_frame(2, 6, 0, 0);
    drive_frame(2, 6, 0, 2);
    expect_frame(2, 6, 1'b0, 1'b0, 1'b1);
    drive_frame(2, 6, 0, 0);
    end_test("drop in skip");
    frame_sel_mode = 2'b00;

    // Reset mid-line: nothing more from that frame, next frame normal.
    capture_en = 1'b1;
    expect_frame(1, 8, 1'b0, 1'b0, 1'b0);
    drive_frame(3, 8, 0, 3);
    check("after reset no pending events", exp_q.size(), 0);
    expect_frame(2, 8, 1'b0, 1'b0, 1'b1);
    drive_frame(2, 8, 0, 0);
    end_test("mid-line reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
